// File: rtl/bit_buffer_scheduler_if.sv
// Handshake bundle between frame writer, bit pixel reader and the ping-pong scheduler.
// Latency: none, wires only.
// Backpressure: wr_ready tells the writer whether its current half is free; otherwise the frame is dropped.
interface bit_buffer_scheduler_if #(
  parameter int DROP_WIDTH = 8
);
  logic                  wr_frame_start;
  logic                  wr_frame_done;
  logic                  wr_ready;
  logic                  wr_buf_index;
  logic                  wr_dropped;
  logic [DROP_WIDTH-1:0] drop_count;
  logic [3:0]            image_number;
  logic                  rd_frame_done;
  logic                  rd_buf_index;
  logic [1:0]            buf_full;
  // Only meaningful when the reader watchdog is built in; held at 0 otherwise.
  logic                  rd_timeout;

  // Writer/reader side: pulses frame events, observes buffer status.
  modport master (
    output wr_frame_start, wr_frame_done, rd_frame_done,
    input  wr_ready, wr_buf_index, wr_dropped, drop_count,
           image_number, rd_buf_index, buf_full, rd_timeout
  );

  // Scheduler side.
  modport slave (
    input  wr_frame_start, wr_frame_done, rd_frame_done,
    output wr_ready, wr_buf_index, wr_dropped, drop_count,
           image_number, rd_buf_index, buf_full, rd_timeout
  );
endinterface

// File: rtl/bit_buffer_scheduler.sv
// Ping-pong scheduler for a two-half frame buffer between a writer and the bit pixel reader.
// Latency: image_number advances one cycle after a half becomes full; wr_dropped one cycle after a rejected start.
// Backpressure: writer is never stalled, a start on a full half is discarded and counted (saturating).
// Optional reader watchdog: define SCHED_RD_WATCHDOG_EN to release a half after RD_TIMEOUT busy cycles.
module bit_buffer_scheduler #(
  parameter int RD_TIMEOUT = 1000000,
  parameter int DROP_WIDTH = 8
) (
  input logic                   pclk,
  input logic                   pclk_reset,
  bit_buffer_scheduler_if.slave bus
);

  typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_DISCARD} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_BUSY}             rd_state_t;

  localparam logic [DROP_WIDTH-1:0] DROP_ONE = {{(DROP_WIDTH-1){1'b0}}, 1'b1};

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic [1:0]            full;
  logic                  wr_idx;
  logic                  rd_idx;
  logic                  wr_dropped_q;
  logic [DROP_WIDTH-1:0] drop_cnt;
  logic [3:0]            img_num;

  logic                  wr_ready;
  logic                  wr_commit;
  logic                  rd_release;
  logic                  rd_wd_fire;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;

  assign wr_ready   = ~full[wr_idx];
  assign wr_commit  = (wr_state == WR_FILL) && bus.wr_frame_done;
  // A watchdog expiry is handled exactly like the reader finishing.
  assign rd_release = (rd_state == RD_BUSY) && (bus.rd_frame_done || rd_wd_fire);
  assign full_set   = wr_commit  ? (wr_idx ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr   = rd_release ? (rd_idx ? 2'b10 : 2'b01) : 2'b00;

`ifdef SCHED_RD_WATCHDOG_EN
  localparam logic [19:0] WD_LAST = 20'(RD_TIMEOUT - 1);

  logic [19:0] wd_cnt;
  logic        rd_timeout_q;

  assign rd_wd_fire = (rd_state == RD_BUSY) && (wd_cnt == WD_LAST);

  // Count reader-busy cycles; flag a stuck reader until the next reset.
  always_ff @(posedge pclk) begin
    if (pclk_reset) begin
      wd_cnt       <= '0;
      rd_timeout_q <= 1'b0;
    end else begin
      if (rd_state != RD_BUSY || rd_release) wd_cnt <= '0;
      else                                   wd_cnt <= wd_cnt + 20'd1;
      if (rd_wd_fire) rd_timeout_q <= 1'b1;
    end
  end

  assign bus.rd_timeout = rd_timeout_q;
`else
  logic unused_timeout;

  assign rd_wd_fire     = 1'b0;
  assign unused_timeout = (RD_TIMEOUT != 0);
  assign bus.rd_timeout = 1'b0;
`endif

  // Full flags: a set and a clear in the same cycle both land; on the same half the set wins.
  always_ff @(posedge pclk) begin
    if (pclk_reset) full <= 2'b00;
    else            full <= (full & ~full_clr) | full_set;
  end

  // Write side: accept into a free half, otherwise swallow the frame and count the drop.
  always_ff @(posedge pclk) begin
    if (pclk_reset) begin
      wr_state     <= WR_IDLE;
      wr_idx       <= 1'b0;
      wr_dropped_q <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      wr_dropped_q <= 1'b0;
      case (wr_state)
        WR_IDLE: begin
          if (bus.wr_frame_start) begin
            if (wr_ready) begin
              wr_state <= WR_FILL;
            end else begin
              wr_state     <= WR_DISCARD;
              wr_dropped_q <= 1'b1;
              if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_ONE;
            end
          end
        end
        WR_FILL: begin
          if (bus.wr_frame_done) begin
            wr_idx   <= ~wr_idx;
            wr_state <= WR_IDLE;
          end
        end
        WR_DISCARD: begin
          if (bus.wr_frame_done) wr_state <= WR_IDLE;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read side: hand each full half to the reader once, advance on completion.
  always_ff @(posedge pclk) begin
    if (pclk_reset) begin
      rd_state <= RD_IDLE;
      rd_idx   <= 1'b0;
      img_num  <= 4'd0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (full[rd_idx]) begin
            rd_state <= RD_BUSY;
            img_num  <= img_num + 4'd1;
          end
        end
        RD_BUSY: begin
          if (rd_release) begin
            rd_idx   <= ~rd_idx;
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.wr_buf_index = wr_idx;
  assign bus.wr_dropped   = wr_dropped_q;
  assign bus.drop_count   = drop_cnt;
  assign bus.image_number = img_num;
  assign bus.rd_buf_index = rd_idx;
  assign bus.buf_full     = full;

endmodule

// File: tb/tb_bit_buffer_scheduler.sv
// Testbench for bit_buffer_scheduler: directed scenarios with literal expectations plus random traffic.
// The reference model tracks frames written / released / issued as plain counters.
// Outputs are compared on every falling edge once the first reset has been applied.
module tb_bit_buffer_scheduler;
  localparam int DW   = 4;
  localparam int TMO  = 50;
  localparam int MAXD = (1 << DW) - 1;

  logic pclk = 1'b0;
  logic pclk_reset;
  int   tests  = 0;
  int   failed = 0;
  bit   chk_en = 1'b0;

  bit_buffer_scheduler_if #(.DROP_WIDTH(DW)) bus ();

  bit_buffer_scheduler #(.RD_TIMEOUT(TMO), .DROP_WIDTH(DW)) dut (
    .pclk       (pclk),
    .pclk_reset (pclk_reset),
    .bus        (bus)
  );

  always #5 pclk = ~pclk;

  // Reference state: counts of committed frames, released halves, issued images.
  int m_written  = 0;
  int m_released = 0;
  int m_issued   = 0;
  int m_wr_mode  = 0;   // 0 idle, 1 filling, 2 discarding
  bit m_rd_busy  = 0;
  int m_busy_cyc = 0;
  int m_drops    = 0;
  bit m_dropped  = 0;
  bit m_timeout  = 0;

  // Halves alternate, so the pending frames are the oldest-unread half and, if two pend, the other one too.
  function automatic bit m_full(int h);
    int pend;
    pend = m_written - m_released;
    return (pend >= 2) || (pend == 1 && h == m_released % 2);
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference model on each rising edge from the inputs held since the previous falling edge.
  always @(posedge pclk) begin : model_step
    bit f_wr, f_rd, commit, rel, iss, fire;
    if (pclk_reset) begin
      m_written = 0; m_released = 0; m_issued = 0; m_wr_mode = 0;
      m_rd_busy = 0; m_busy_cyc = 0; m_drops = 0; m_dropped = 0; m_timeout = 0;
    end else begin
      f_wr = m_full(m_written % 2);
      f_rd = m_full(m_released % 2);
      fire = 1'b0;
`ifdef SCHED_RD_WATCHDOG_EN
      fire = m_rd_busy && (m_busy_cyc == TMO - 1);
`endif
      commit    = (m_wr_mode == 1) && bus.wr_frame_done;
      rel       = m_rd_busy && (bus.rd_frame_done || fire);
      iss       = !m_rd_busy && f_rd;
      m_dropped = 1'b0;
      if (m_wr_mode == 0) begin
        if (bus.wr_frame_start) begin
          if (!f_wr) m_wr_mode = 1;
          else begin
            m_wr_mode = 2;
            m_dropped = 1'b1;
            if (m_drops < MAXD) m_drops++;
          end
        end
      end else if (bus.wr_frame_done) begin
        m_wr_mode = 0;
      end
      if (commit) m_written++;
      if (rel) begin
        m_released++;
        m_rd_busy = 1'b0;
        if (fire) m_timeout = 1'b1;
      end
      if (iss) begin
        m_issued++;
        m_rd_busy = 1'b1;
      end
      m_busy_cyc = (m_rd_busy && !iss) ? m_busy_cyc + 1 : 0;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge pclk) begin
    if (chk_en) begin
      chk("wr_ready",     bus.wr_ready,     !m_full(m_written % 2));
      chk("wr_buf_index", bus.wr_buf_index, m_written % 2);
      chk("wr_dropped",   bus.wr_dropped,   m_dropped);
      chk("drop_count",   bus.drop_count,   m_drops);
      chk("image_number", bus.image_number, m_issued % 16);
      chk("rd_buf_index", bus.rd_buf_index, m_released % 2);
      chk("buf_full",     bus.buf_full,     m_full(1) * 2 + m_full(0));
      chk("rd_timeout",   bus.rd_timeout,   m_timeout);
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic do_reset();
    pclk_reset = 1'b1;
    step(2);
    pclk_reset = 1'b0;
  endtask

  task automatic pulse_start();
    bus.wr_frame_start = 1'b1; step(1); bus.wr_frame_start = 1'b0;
  endtask

  task automatic pulse_wdone();
    bus.wr_frame_done = 1'b1; step(1); bus.wr_frame_done = 1'b0;
  endtask

  task automatic pulse_rdone();
    bus.rd_frame_done = 1'b1; step(1); bus.rd_frame_done = 1'b0;
  endtask

  initial begin
    bus.wr_frame_start = 1'b0;
    bus.wr_frame_done  = 1'b0;
    bus.rd_frame_done  = 1'b0;
    pclk_reset         = 1'b1;
    step(2);
    pclk_reset = 1'b0;
    chk_en     = 1'b1;

    // Reset state.
    chk("rst_buf_full", bus.buf_full, 0);
    chk("rst_image", bus.image_number, 0);
    chk("rst_drop_count", bus.drop_count, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);

    // First frame: start and done ten cycles apart, handoff one cycle after the full flag.
    pulse_start();
    step(9);
    pulse_wdone();
    chk("f1_buf_full", bus.buf_full, 1);
    chk("f1_wr_idx", bus.wr_buf_index, 1);
    chk("f1_image_before", bus.image_number, 0);
    step(1);
    chk("f1_image_after", bus.image_number, 1);

    // Fill half 1 with the reader still busy, then a third frame must be dropped.
    pulse_start();
    pulse_wdone();
    chk("both_full", bus.buf_full, 3);
    chk("both_full_wr_ready", bus.wr_ready, 0);
    pulse_start();
    chk("drop_pulse", bus.wr_dropped, 1);
    chk("drop_count_1", bus.drop_count, 1);
    step(1);
    chk("drop_pulse_end", bus.wr_dropped, 0);
    chk("drop_buf_full", bus.buf_full, 3);
    chk("drop_image", bus.image_number, 1);
    pulse_wdone();
    chk("drop_wr_idx_kept", bus.wr_buf_index, 0);

    // Reader finishes half 0 while half 1 waits: no reissue in the same cycle.
    pulse_rdone();
    chk("rel_buf_full", bus.buf_full, 2);
    chk("rel_rd_idx", bus.rd_buf_index, 1);
    chk("rel_image_same", bus.image_number, 1);
    step(1);
    chk("rel_image_next", bus.image_number, 2);
    pulse_rdone();
    chk("drain_buf_full", bus.buf_full, 0);

    // Seventeen frames with a prompt reader: 1..15, 0, 1.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      pulse_start();
      pulse_wdone();
      step(1);
      chk("seq_image", bus.image_number, i % 16);
      pulse_rdone();
    end

    // Reset in the middle of filling half 1 abandons it without a drop.
    do_reset();
    pulse_start();
    pulse_wdone();
    pulse_start();
    chk("midfill_buf_full", bus.buf_full, 1);
    do_reset();
    chk("midrst_buf_full", bus.buf_full, 0);
    chk("midrst_image", bus.image_number, 0);
    chk("midrst_wr_idx", bus.wr_buf_index, 0);
    chk("midrst_drops", bus.drop_count, 0);
    pulse_start();
    pulse_wdone();
    chk("postrst_buf_full", bus.buf_full, 1);
    chk("postrst_wr_idx", bus.wr_buf_index, 1);

`ifdef SCHED_RD_WATCHDOG_EN
    // Reader held busy: released on the fiftieth busy cycle.
    do_reset();
    pulse_start();
    pulse_wdone();
    step(1);
    step(TMO - 1);
    chk("wd_before", bus.rd_timeout, 0);
    step(1);
    chk("wd_fired", bus.rd_timeout, 1);
    chk("wd_buf_full", bus.buf_full, 0);
    chk("wd_rd_idx", bus.rd_buf_index, 1);
    pulse_start();
    pulse_wdone();
    step(1);
    chk("wd_next_image", bus.image_number, 2);
    chk("wd_sticky", bus.rd_timeout, 1);
`else
    // Without the watchdog a busy reader holds its half indefinitely.
    do_reset();
    pulse_start();
    pulse_wdone();
    step(200);
    chk("nowd_timeout", bus.rd_timeout, 0);
    chk("nowd_buf_full", bus.buf_full, 1);
    // Drop counter saturates at all ones.
    pulse_start();
    pulse_wdone();
    for (int i = 0; i < MAXD + 3; i++) begin
      pulse_start();
      pulse_wdone();
    end
    chk("sat_drop_count", bus.drop_count, MAXD);
`endif

    // Random traffic, including out-of-state pulses and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      pclk_reset         = ($urandom_range(0, 299) == 0);
      bus.wr_frame_start = ($urandom_range(0, 99) < 25);
      bus.wr_frame_done  = ($urandom_range(0, 99) < 30);
`ifdef SCHED_RD_WATCHDOG_EN
      bus.rd_frame_done  = ($urandom_range(0, 99) < 2);
`else
      bus.rd_frame_done  = ($urandom_range(0, 99) < 20);
`endif
      step(1);
    end
    pclk_reset         = 1'b0;
    bus.wr_frame_start = 1'b0;
    bus.wr_frame_done  = 1'b0;
    bus.rd_frame_done  = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/bit_buffer_scheduler.md
BIT_BUFFER_SCHEDULER -- requirements
Module: bit_buffer_scheduler

Interface
REQ-001 The parameter list SHALL be: RD_TIMEOUT, default 1000000, maximum reader-busy cycles before the watchdog fires.
REQ-002 The parameter list SHALL be: DROP_WIDTH, default 8, width of the dropped-frame counter.
REQ-003 The clock port SHALL be: pclk  in  1  single clock for all logic.
REQ-004 The reset port SHALL be: pclk_reset  in  1  synchronous, active-high reset.
REQ-005 The port list SHALL include: wr_frame_start  in  1  one-cycle pulse, writer begins a frame.
REQ-006 The port list SHALL include: wr_frame_done  in  1  one-cycle pulse, writer finished the frame.
REQ-007 The port list SHALL include: wr_ready  out  1  current write half is free.
REQ-008 The port list SHALL include: wr_buf_index  out  1  half the writer fills (0 = low addresses, 1 = upper).
REQ-009 The port list SHALL include: wr_dropped  out  1  one-cycle pulse, frame discarded.
REQ-010 The port list SHALL include: drop_count  out  DROP_WIDTH  saturating dropped-frame count.
REQ-011 The port list SHALL include: image_number  out  4  handoff token to the bit pixel reader.
REQ-012 The port list SHALL include: rd_frame_done  in  1  one-cycle pulse, reader returned to idle.
REQ-013 The port list SHALL include: rd_buf_index  out  1  half the reader is consuming.
REQ-014 The port list SHALL include: buf_full  out  2  per-half full flags.
REQ-015 The port list SHALL include: rd_timeout  out  1  sticky watchdog error (exists only with the macro; see Configuration).

Function
REQ-016 The halves SHALL be tracked by full[1:0]; wr_ready = !full[wr_buf_index], combinational.
REQ-017 The write FSM SHALL have states WR_IDLE, WR_FILL and WR_DISCARD.
- WR_IDLE + wr_frame_start + wr_ready -> WR_FILL.
- WR_IDLE + wr_frame_start + !wr_ready -> WR_DISCARD; wr_dropped pulses the next cycle; drop_count +1, saturating at all-ones.
REQ-018 In WR_FILL, wr_frame_done SHALL set full[wr_buf_index], toggle wr_buf_index and return to WR_IDLE.
REQ-019 In WR_DISCARD, wr_frame_done SHALL return to WR_IDLE with no change to full or wr_buf_index.
REQ-020 wr_frame_start outside WR_IDLE SHALL be ignored; wr_frame_done in WR_IDLE SHALL be ignored.
REQ-021 The read FSM SHALL have states RD_IDLE and RD_BUSY.
- RD_IDLE with full[rd_buf_index]=1 -> RD_BUSY and image_number <= image_number+1 (mod 16, 15 wraps to 0), exactly one increment per half.
- Handoff latency: image_number changes on the cycle after the full flag is set.
REQ-022 In RD_BUSY, rd_frame_done SHALL clear full[rd_buf_index], toggle rd_buf_index and return to RD_IDLE; rd_frame_done in RD_IDLE SHALL be ignored.
REQ-023 A set of one full bit and a clear of the other in the same cycle SHALL both take effect.
- Both may target the same half only after a watchdog release; in that case the set wins.
REQ-024 A new image_number SHALL NOT be issued in the same cycle that rd_frame_done is accepted; the earliest re-issue is the following cycle.
REQ-025 Halves SHALL strictly alternate on both sides, so the reader's internal buffer toggle stays aligned with rd_buf_index.

Reset
REQ-026 Reset SHALL apply on any pclk edge with pclk_reset=1 and override all other inputs, including mid-frame.
REQ-027 On reset, all registered outputs SHALL clear: full=00, wr_buf_index=0, rd_buf_index=0, image_number=0, drop_count=0, wr_dropped=0, rd_timeout=0, both FSMs idle.
REQ-028 Any frame in progress at reset SHALL be abandoned without a drop count.

Configuration
REQ-029 Macro SCHED_RD_WATCHDOG_EN SHALL control the reader watchdog.
- Defined: a 20-bit counter runs in RD_BUSY and clears on leaving RD_BUSY.
- On reaching RD_TIMEOUT, the block treats it as rd_frame_done and sets rd_timeout, sticky until reset.
- Undefined: no counter; rd_timeout is tied to 0; RD_BUSY waits indefinitely.

Verification
REQ-030 Reset, then start and done 10 cycles apart: buf_full=01, image_number 0->1 one cycle later, wr_buf_index=1.
REQ-031 Fill both halves with no rd_frame_done, then a third start: wr_dropped pulses once, drop_count=1, buf_full stays 11, image_number=1.
REQ-032 rd_frame_done in RD_BUSY on half 0 while half 1 is full: buf_full=10, rd_buf_index=1, image_number=2 on the following cycle.
REQ-033 Issue 17 frames with a prompt reader: image_number sequence 1..15, 0, 1, with no increment skipped.
REQ-034 Apply pclk_reset during WR_FILL with buf_full=01: all outputs return to reset values, and a subsequent frame lands in half 0.
REQ-035 With SCHED_RD_WATCHDOG_EN defined and RD_TIMEOUT=50, hold the reader busy: at cycle 50, rd_timeout=1, the half is released and the next issue proceeds.
